spine_port_endpoint: RTL and testbench

//  Fabric-side terminator for one group-router spine port (spineN3_*). Absorbs the

---
 rtl/spine_pkg.sv | 15 +
 rtl/spine_sync_fifo.sv | 54 +++++
 rtl/spine_port_endpoint.sv | 134 +++++++++++++
 tb/tb_spine_port_endpoint.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// Shared definitions for the spine port endpoint: destination field location
// within a flit header and the egress state encoding.
package spine_pkg;

  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 10;
  localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } egress_state_e;

endpackage

// File: rtl/spine_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head data reads as zero when empty.
module spine_sync_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; validity is tracked by level and pointers only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spine_port_endpoint.sv
// Fabric-side terminator for one router spine port: ingress FIFO toward the fabric,
// paced egress replay into the router. Optional counters under SPINE_EP_STATS_EN.
module spine_port_endpoint
  import spine_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int DEST_W     = spine_pkg::DEST_W,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [DWIDTH-1:0] rtr_out_data,
  input  logic              rtr_out_valid,
  output logic [DWIDTH-1:0] rtr_in_data,
  output logic              rtr_in_valid,
  output logic [DEST_W-1:0] rtr_dest_addr,
  output logic [DWIDTH-1:0] fab_tx_data,
  output logic              fab_tx_valid,
  input  logic              fab_tx_ready,
  input  logic [DWIDTH-1:0] fab_rx_data,
  input  logic              fab_rx_valid,
  output logic              fab_rx_ready,
  output logic              ovf_sticky,
`ifdef SPINE_EP_STATS_EN
  output logic [15:0]       tx_flit_cnt,
  output logic [15:0]       rx_flit_cnt,
  output logic [7:0]        drop_cnt,
`endif
  output logic [LW-1:0]     fifo_level
);

  // ---------------- Ingress: router -> fabric ----------------
  logic fifo_full;
  logic fifo_empty;
  logic tx_pop;
  logic drop;

  assign fab_tx_valid = !fifo_empty;
  assign tx_pop       = fab_tx_valid && fab_tx_ready;
  assign drop         = rtr_out_valid && fifo_full && !tx_pop;

  spine_sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_ingress_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .push      (rtr_out_valid),
    .push_data (rtr_out_data),
    .pop       (tx_pop),
    .head_data (fab_tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn)  ovf_sticky <= 1'b0;
    else if (drop) ovf_sticky <= 1'b1;
  end

  // ---------------- Egress: fabric -> router ----------------
  egress_state_e     state_q, state_d;
  logic [DWIDTH-1:0] hold_q, hold_d;
  logic [3:0]        gap_q, gap_d;
  logic              rx_ready_q;
  logic              accept;

  assign accept = fab_rx_valid && fab_rx_ready;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = fab_rx_data;
          state_d = SEND;
        end
      end
      SEND: begin
        if (GAP_CYCLES == 0) begin
          if (accept) hold_d = fab_rx_data;
          else        state_d = IDLE;
        end else begin
          gap_d   = 4'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered from the next state so it is low throughout reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      gap_q      <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      rx_ready_q <= (state_d == IDLE) || ((state_d == SEND) && (GAP_CYCLES == 0));
    end
  end

  assign fab_rx_ready  = rx_ready_q;
  assign rtr_in_valid  = (state_q == SEND);
  assign rtr_in_data   = rtr_in_valid ? hold_q : '0;
  assign rtr_dest_addr = rtr_in_data[DWIDTH-1 -: DEST_W];

`ifdef SPINE_EP_STATS_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tx_flit_cnt <= '0;
      rx_flit_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (tx_pop)       tx_flit_cnt <= tx_flit_cnt + 1'b1;
      if (rtr_in_valid) rx_flit_cnt <= rx_flit_cnt + 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spine_port_endpoint.sv
// Directed bench for spine_port_endpoint: one instance with GAP_CYCLES=1 (g1) and
// one with GAP_CYCLES=0 (g0) driven from the same stimulus.
module tb_spine_port_endpoint;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] rtr_out_data = '0;
  logic        rtr_out_valid = 1'b0;
  logic        fab_tx_ready = 1'b0;
  logic [15:0] fab_rx_data = '0;
  logic        fab_rx_valid = 1'b0;

  logic [15:0] g1_rtr_in_data, g0_rtr_in_data;
  logic        g1_rtr_in_valid, g0_rtr_in_valid;
  logic [5:0]  g1_rtr_dest_addr, g0_rtr_dest_addr;
  logic [15:0] g1_fab_tx_data, g0_fab_tx_data;
  logic        g1_fab_tx_valid, g0_fab_tx_valid;
  logic        g1_fab_rx_ready, g0_fab_rx_ready;
  logic        g1_ovf_sticky, g0_ovf_sticky;
  logic [3:0]  g1_fifo_level, g0_fifo_level;
`ifdef SPINE_EP_STATS_EN
  logic [15:0] g1_tx_cnt, g1_rx_cnt, g0_tx_cnt, g0_rx_cnt;
  logic [7:0]  g1_drop_cnt, g0_drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  spine_port_endpoint #(.DWIDTH(16), .DEPTH(8), .GAP_CYCLES(1), .DEST_W(6)) dut_g1 (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .rtr_out_data  (rtr_out_data),
    .rtr_out_valid (rtr_out_valid),
    .rtr_in_data   (g1_rtr_in_data),
    .rtr_in_valid  (g1_rtr_in_valid),
    .rtr_dest_addr (g1_rtr_dest_addr),
    .fab_tx_data   (g1_fab_tx_data),
    .fab_tx_valid  (g1_fab_tx_valid),
    .fab_tx_ready  (fab_tx_ready),
    .fab_rx_data   (fab_rx_data),
    .fab_rx_valid  (fab_rx_valid),
    .fab_rx_ready  (g1_fab_rx_ready),
    .ovf_sticky    (g1_ovf_sticky),
`ifdef SPINE_EP_STATS_EN
    .tx_flit_cnt   (g1_tx_cnt),
    .rx_flit_cnt   (g1_rx_cnt),
    .drop_cnt      (g1_drop_cnt),
`endif
    .fifo_level    (g1_fifo_level)
  );

  spine_port_endpoint #(.DWIDTH(16), .DEPTH(8), .GAP_CYCLES(0), .DEST_W(6)) dut_g0 (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .rtr_out_data  (rtr_out_data),
    .rtr_out_valid (rtr_out_valid),
    .rtr_in_data   (g0_rtr_in_data),
    .rtr_in_valid  (g0_rtr_in_valid),
    .rtr_dest_addr (g0_rtr_dest_addr),
    .fab_tx_data   (g0_fab_tx_data),
    .fab_tx_valid  (g0_fab_tx_valid),
    .fab_tx_ready  (fab_tx_ready),
    .fab_rx_data   (fab_rx_data),
    .fab_rx_valid  (fab_rx_valid),
    .fab_rx_ready  (g0_fab_rx_ready),
    .ovf_sticky    (g0_ovf_sticky),
`ifdef SPINE_EP_STATS_EN
    .tx_flit_cnt   (g0_tx_cnt),
    .rx_flit_cnt   (g0_rx_cnt),
    .drop_cnt      (g0_drop_cnt),
`endif
    .fifo_level    (g0_fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [15:0] burst [4];
    burst[0] = 16'h1111; burst[1] = 16'h2222; burst[2] = 16'h4444; burst[3] = 16'h8888;

    // 1. Reset then idle
    repeat (3) tick();
    check("rst_rx_ready",  32'(g1_fab_rx_ready), 32'd0);
    check("rst_tx_valid",  32'(g1_fab_tx_valid), 32'd0);
    check("rst_tx_data",   32'(g1_fab_tx_data),  32'd0);
    check("rst_in_valid",  32'(g1_rtr_in_valid), 32'd0);
    check("rst_in_data",   32'(g1_rtr_in_data),  32'd0);
    check("rst_dest",      32'(g1_rtr_dest_addr), 32'd0);
    check("rst_ovf",       32'(g1_ovf_sticky),   32'd0);
    check("rst_level",     32'(g1_fifo_level),   32'd0);
    ARESETn = 1'b1;
    tick();
    check("idle_rx_ready",    32'(g1_fab_rx_ready), 32'd1);
    check("idle_rx_ready_g0", 32'(g0_fab_rx_ready), 32'd1);
    check("idle_level",       32'(g1_fifo_level),   32'd0);

    // 2. Ingress ordering, stable head under backpressure
    rtr_out_valid = 1'b1; rtr_out_data = 16'hA5C3;
    check("no_bypass_valid", 32'(g1_fab_tx_valid), 32'd0);
    tick();
    check("push1_valid", 32'(g1_fab_tx_valid), 32'd1);
    rtr_out_data = 16'h1234;
    tick();
    rtr_out_valid = 1'b0;
    check("push2_level", 32'(g1_fifo_level),  32'd2);
    check("push2_head",  32'(g1_fab_tx_data), 32'h0000A5C3);
    tick();
    check("stall_head",  32'(g1_fab_tx_data), 32'h0000A5C3);
    check("stall_level", 32'(g1_fifo_level),  32'd2);
    fab_tx_ready = 1'b1;
    tick();
    check("pop1_head",  32'(g1_fab_tx_data), 32'h00001234);
    check("pop1_level", 32'(g1_fifo_level),  32'd1);
    tick();
    check("pop2_level", 32'(g1_fifo_level),   32'd0);
    check("pop2_valid", 32'(g1_fab_tx_valid), 32'd0);
    fab_tx_ready = 1'b0;

    // 3. Overflow: 9 pushes into DEPTH=8, then push+pop while full
    for (int i = 0; i < 9; i++) begin
      rtr_out_valid = 1'b1; rtr_out_data = 16'h0100 + 16'(i);
      tick();
    end
    check("ovf_level",  32'(g1_fifo_level),  32'd8);
    check("ovf_sticky", 32'(g1_ovf_sticky),  32'd1);
    check("ovf_head",   32'(g1_fab_tx_data), 32'h00000100);
    rtr_out_data = 16'h0BEE; fab_tx_ready = 1'b1;
    tick();
    rtr_out_valid = 1'b0;
    check("full_pushpop_level", 32'(g1_fifo_level), 32'd8);
    check("full_pushpop_ovf",   32'(g1_ovf_sticky), 32'd1);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(g1_fab_tx_data), 32'h0100 + 32'(i));
      tick();
    end
    check("drain_last",  32'(g1_fab_tx_data), 32'h00000BEE);
    tick();
    check("drain_level", 32'(g1_fifo_level), 32'd0);
    fab_tx_ready = 1'b0;

    // 4. Egress with GAP_CYCLES=1
    check("eg_pre_ready", 32'(g1_fab_rx_ready), 32'd1);
    fab_rx_valid = 1'b1; fab_rx_data = 16'hFC01;
    tick();
    fab_rx_valid = 1'b0; fab_rx_data = '0;
    check("eg_n1_valid", 32'(g1_rtr_in_valid),  32'd1);
    check("eg_n1_data",  32'(g1_rtr_in_data),   32'h0000FC01);
    check("eg_n1_dest",  32'(g1_rtr_dest_addr), 32'h3F);
    check("eg_n1_ready", 32'(g1_fab_rx_ready),  32'd0);
    tick();
    check("eg_n2_valid", 32'(g1_rtr_in_valid),  32'd0);
    check("eg_n2_data",  32'(g1_rtr_in_data),   32'd0);
    check("eg_n2_dest",  32'(g1_rtr_dest_addr), 32'd0);
    check("eg_n2_ready", 32'(g1_fab_rx_ready),  32'd0);
    tick();
    check("eg_n3_ready", 32'(g1_fab_rx_ready),  32'd1);
    check("eg_n3_valid", 32'(g1_rtr_in_valid),  32'd0);

    // 5. GAP_CYCLES=0 back-to-back
    for (int i = 0; i < 4; i++) begin
      fab_rx_valid = 1'b1; fab_rx_data = burst[i];
      tick();
      check($sformatf("b2b_valid_%0d", i), 32'(g0_rtr_in_valid), 32'd1);
      check($sformatf("b2b_data_%0d", i),  32'(g0_rtr_in_data),  32'(burst[i]));
      check($sformatf("b2b_ready_%0d", i), 32'(g0_fab_rx_ready), 32'd1);
    end
    fab_rx_valid = 1'b0; fab_rx_data = '0;
    tick();
    check("b2b_end_valid", 32'(g0_rtr_in_valid), 32'd0);
    repeat (4) tick();
    check("settle_g1_ready", 32'(g1_fab_rx_ready), 32'd1);

    // 6. Reset while in SEND with three flits queued
    for (int i = 0; i < 3; i++) begin
      rtr_out_valid = 1'b1; rtr_out_data = 16'h0C00 + 16'(i);
      if (i == 2) begin
        fab_rx_valid = 1'b1; fab_rx_data = 16'h8421;
      end
      tick();
    end
    rtr_out_valid = 1'b0; fab_rx_valid = 1'b0; fab_rx_data = '0;
    check("pre_rst_send",  32'(g1_rtr_in_valid),  32'd1);
    check("pre_rst_dest",  32'(g1_rtr_dest_addr), 32'h21);
    check("pre_rst_level", 32'(g1_fifo_level),    32'd3);
    ARESETn = 1'b0;
    tick();
    check("mid_rst_valid", 32'(g1_rtr_in_valid), 32'd0);
    check("mid_rst_level", 32'(g1_fifo_level),   32'd0);
    check("mid_rst_ovf",   32'(g1_ovf_sticky),   32'd0);
    check("mid_rst_tx",    32'(g1_fab_tx_valid), 32'd0);
    check("mid_rst_ready", 32'(g1_fab_rx_ready), 32'd0);
    ARESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", i), 32'(g1_rtr_in_valid), 32'd0);
    end
    check("post_rst_ready", 32'(g1_fab_rx_ready), 32'd1);
    check("post_rst_level", 32'(g1_fifo_level),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
